// File: rtl/led_pkg.sv
// Shared definitions for the front-panel indicator driver: channel mode
// encodings and a constant-evaluable ceil(log2) used to size counters.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PULSE = 2'b11;

  // Never returns less than 1 so that every counter has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/led_chan.sv
// One indicator channel: event edge detect, pulse-stretch counter and the
// mode multiplexer producing the next value of this channel's output bit.
module led_chan
  import led_pkg::*;
#(
  parameter int STRETCH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       phase,
  input  logic [1:0] mode,
  input  logic       code,
  input  logic       evt,
  output logic       bnc_next
);

  localparam int              CW   = clog2(STRETCH + 1);
  localparam logic [CW-1:0]   LOAD = CW'(STRETCH);

  logic          event_d;
  logic          rise;
  logic [CW-1:0] cnt;

  assign rise = evt & ~event_d;

  // A fresh edge always reloads, even on a tick cycle, so a retrigger never
  // loses the decrement race; the counter keeps running whatever the mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_d <= 1'b0;
      cnt     <= '0;
    end else begin
      event_d <= evt;
      if (rise) begin
        cnt <= LOAD;
      end else if (tick && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    bnc_next = 1'b0;
    case (mode)
      MODE_OFF:   bnc_next = 1'b0;
      MODE_ON:    bnc_next = 1'b1;
      MODE_BLINK: bnc_next = phase ^ ~code;
      MODE_PULSE: bnc_next = (cnt != '0);
      default:    bnc_next = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Front-panel indicator driver: shared prescaler and blink phase, one
// led_chan per channel, a registered BNC monitor output and its LED inverse.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DIV     = 25_000_000,
  parameter int STRETCH = 4
) (
  input  logic [0:0]        clk,
  input  logic              rst_n,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   code,
  input  logic [N_CH-1:0]   evt,
  output logic [N_CH-1:0]   leds,
  output logic [N_CH-1:0]   bnc,
  output logic [N_CH-1:0]   gnd
);

  localparam int            PW      = clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0]   pre;
  logic            tick;
  logic            phase;
  logic [N_CH-1:0] bnc_next;

  assign tick = (pre == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      phase <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        phase <= ~phase;
      end
    end
  end

  // evt carries the board event levels; each channel edge-detects its own bit.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    led_chan #(
      .STRETCH (STRETCH)
    ) u_chan (
      .clk      (clk[0]),
      .rst_n    (rst_n),
      .tick     (tick),
      .phase    (phase),
      .mode     (mode[2*i+1:2*i]),
      .code     (code[i]),
      .evt      (evt[i]),
      .bnc_next (bnc_next[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnc <= '0;
    end else begin
      bnc <= bnc_next;
    end
  end

  assign leds = ~bnc;
  assign gnd  = '0;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Scoreboard bench for led_pattern_driver with N_CH=4, DIV=4, STRETCH=3:
// stimulus queues hand-computed bnc values per cycle, a monitor checks them.
module tb_led_pattern_driver;

  localparam int N_CH    = 4;
  localparam int DIV     = 4;
  localparam int STRETCH = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mode  = '0;
  logic [3:0] code  = '0;
  logic [3:0] evt   = '0;
  logic [3:0] leds;
  logic [3:0] bnc;
  logic [3:0] gnd;

  typedef struct {
    int         cyc;
    logic [3:0] bnc;
    bit         async;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   base   = 0;
  int   tests  = 0;
  int   failed = 0;

  led_pattern_driver #(
    .N_CH    (N_CH),
    .DIV     (DIV),
    .STRETCH (STRETCH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .code  (code),
    .evt   (evt),
    .leds  (leds),
    .bnc   (bnc),
    .gnd   (gnd)
  );

  always #5 clk = ~clk;

  task automatic check_output(input exp_t e);
    tests++;
    if (bnc !== e.bnc || leds !== ~e.bnc || gnd !== 4'b0000) begin
      failed++;
      $display("[TB] FAIL %s @cyc %0d: got bnc=%b leds=%b gnd=%b, want bnc=%b leds=%b gnd=0000",
               e.name, e.cyc, bnc, leds, gnd, e.bnc, ~e.bnc);
    end
  endtask

  // Cycle count advances just after each edge, then due entries are checked.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    while (sb.size() > 0 && !sb[0].async && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        tests++;
        failed++;
        $display("[TB] FAIL %s @cyc %0d: check missed, now cyc %0d", e.name, e.cyc, cyc);
      end else begin
        check_output(e);
      end
    end
  end

  always @(negedge rst_n) begin
    exp_t e;
    #1;
    while (sb.size() > 0 && sb[0].async) begin
      e = sb.pop_front();
      check_output(e);
    end
  end

  task automatic push(input int k, input logic [3:0] v, input string name, input bit async = 1'b0);
    exp_t e;
    e.cyc   = base + k;
    e.bnc   = v;
    e.async = async;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic push_range(input int k0, input int k1, input logic [3:0] v, input string name);
    for (int k = k0; k <= k1; k++) push(k, v, name);
  endtask

  task automatic go(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic apply_stimulus();
    // Reset held with arbitrary inputs.
    mode = 8'hFF;
    code = 4'hA;
    evt  = 4'hF;
    push_range(1, 3, 4'b0000, "reset_hold");
    go(3);
    mode  = 8'h00;
    code  = 4'h0;
    evt   = 4'h0;
    rst_n = 1'b1;
    base  = cyc;
    push(1, 4'b0000, "idle");

    go(1);
    mode = 8'b01_00_01_01;
    push(2, 4'b1011, "static");

    // Blink: first tick in the cycle after edge 3, so phase flips at edges 4, 8, 12.
    go(2);
    mode = 8'b10_10_10_10;
    code = 4'b0101;
    for (int k = 3; k <= 16; k++)
      push(k, ((((k - 1) / 4) % 2) == 0) ? 4'b1010 : 4'b0101, "blink");

    // Single pulse: load at edge 18, decrements at 20, 24, 28.
    go(16);
    mode = 8'b00_00_00_11;
    push_range(17, 18, 4'b0000, "pulse_pre");
    push_range(19, 28, 4'b0001, "pulse_hi");
    push_range(29, 30, 4'b0000, "pulse_lo");
    go(17);
    evt = 4'b0001;
    go(18);
    evt = 4'b0000;

    // Retrigger at cnt=1 coinciding with the tick before edge 44, then held high.
    push_range(31, 33, 4'b0000, "retrig_pre");
    push_range(34, 56, 4'b0001, "retrig_hi");
    push_range(57, 66, 4'b0000, "held_lo");
    go(32);
    evt = 4'b0001;
    go(33);
    evt = 4'b0000;
    go(43);
    evt = 4'b0001;
    go(63);
    evt = 4'b0000;

    // Mode switching during a stretch loaded at edge 69, reaching 0 at edge 80.
    push_range(67, 69, 4'b0000, "sw_pre");
    push(70, 4'b0001, "sw_pulse");
    push_range(71, 73, 4'b0000, "sw_off");
    push_range(74, 80, 4'b0001, "sw_on");
    push_range(81, 83, 4'b0000, "sw_back");
    go(68);
    evt = 4'b0001;
    go(69);
    evt = 4'b0000;
    go(70);
    mode = 8'b00_00_00_00;
    go(73);
    mode = 8'b00_00_00_01;
    go(80);
    mode = 8'b00_00_00_11;

    // Reset asserted mid-pulse.
    push_range(84, 85, 4'b0000, "rp_pre");
    push_range(86, 88, 4'b0001, "rp_hi");
    go(84);
    evt = 4'b0001;
    go(85);
    evt = 4'b0000;
    go(88);
    push(88, 4'b0000, "reset_async", 1'b1);
    rst_n = 1'b0;
    push_range(89, 90, 4'b0000, "rp_in_reset");

    // After release: stretch state cleared, first tick DIV cycles later.
    go(90);
    mode  = 8'b10_10_10_11;
    code  = 4'b1110;
    rst_n = 1'b1;
    base  = cyc;
    push_range(1, 4, 4'b0000, "post_lo");
    push_range(5, 8, 4'b1110, "post_hi");
    push_range(9, 10, 4'b0000, "post_lo2");
  endtask

  initial begin
    apply_stimulus();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("[TB] FAIL drain: %0d checks still pending, required 0", sb.size());
      failed += sb.size();
      tests  += sb.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, pending %0d", sb.size());
    $fatal(1, "[TB] watchdog");
  end

endmodule
